// File: rtl/alu_pwr_ctrl.sv
// Power-sequencing and request controller for the power-gated ALU.
// Wakes the ALU on demand, grants one start at a time, and isolates before cutting power.
module alu_pwr_ctrl #(
  parameter int unsigned PWR_UP_CYC = 8,
  parameter int unsigned ISO_CYC    = 2,
  parameter int unsigned PWR_DN_CYC = 4,
  parameter int unsigned IDLE_CYC   = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_req,
  output logic       op_gnt,
  output logic       alu_start,
  input  logic       alu_busy,
  input  logic       auto_sleep_en,
  input  logic       force_sleep,
  output logic       alu_pwr_en,
  output logic       iso_en,
  output logic [2:0] pwr_state
);

  typedef enum logic [2:0] {
    StOff   = 3'd0,
    StPwrUp = 3'd1,
    StOn    = 3'd2,
    StIsoOn = 3'd3,
    StPwrDn = 3'd4
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] idle_q;
  logic             gnt_q;
  logic             start_q;
  logic             pwr_q;
  logic             iso_q;

  logic             grant;
  logic             idle;
  logic             idle_hit;
  logic             sleep_req;
  logic [CNT_W-1:0] idle_inc;

  always_comb begin
    // gnt_q guards the cycle before the ALU's busy flag can rise.
    grant     = (state_q == StOn) && op_req && !alu_busy && !force_sleep && !gnt_q;
    idle      = (state_q == StOn) && !op_req && !alu_busy && !gnt_q;
    idle_inc  = (idle_q >= CNT_W'(IDLE_CYC)) ? idle_q : idle_q + 1'b1;
    idle_hit  = idle && auto_sleep_en && (idle_inc >= CNT_W'(IDLE_CYC));
    sleep_req = (force_sleep && !alu_busy) || idle_hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StOff;
      cnt_q   <= '0;
      idle_q  <= '0;
      gnt_q   <= 1'b0;
      start_q <= 1'b0;
      pwr_q   <= 1'b0;
      iso_q   <= 1'b1;
    end else begin
      gnt_q   <= grant;
      start_q <= grant;
      unique case (state_q)
        StOff: begin
          if (op_req && !force_sleep) begin
            state_q <= StPwrUp;
            cnt_q   <= CNT_W'(PWR_UP_CYC);
            pwr_q   <= 1'b1;
            iso_q   <= 1'b1;
          end
        end
        StPwrUp: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_q <= StOn;
            cnt_q   <= '0;
            idle_q  <= '0;
            iso_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StOn: begin
          if (sleep_req) begin
            state_q <= StIsoOn;
            cnt_q   <= CNT_W'(ISO_CYC);
            idle_q  <= '0;
            iso_q   <= 1'b1;
          end else begin
            idle_q <= idle ? idle_inc : '0;
          end
        end
        StIsoOn: begin
          // Clamp is already up; power may only drop once ISO_CYC cycles have passed.
          if (cnt_q <= CNT_W'(1)) begin
            state_q <= StPwrDn;
            cnt_q   <= CNT_W'(PWR_DN_CYC);
            pwr_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StPwrDn: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_q <= StOff;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= StOff;
          cnt_q   <= '0;
          idle_q  <= '0;
          pwr_q   <= 1'b0;
          iso_q   <= 1'b1;
        end
      endcase
    end
  end

  assign op_gnt     = gnt_q;
  assign alu_start  = start_q;
  assign alu_pwr_en = pwr_q;
  assign iso_en     = iso_q;
  assign pwr_state  = state_q;

  iso_needs_pwr_a: assert property (@(posedge clk) disable iff (!rst_n) !iso_q |-> pwr_q);
  start_in_on_a: assert property (@(posedge clk) disable iff (!rst_n)
                                  start_q |-> (state_q == StOn));

endmodule

// File: tb/tb_alu_pwr_ctrl.sv
// Bench for alu_pwr_ctrl: a cycle model feeds a scoreboard of expected outputs, plus
// directed latency checks and an ALU stand-in that holds busy for 5 cycles per start.
module tb_alu_pwr_ctrl;
  localparam int unsigned PWR_UP_CYC = 8;
  localparam int unsigned ISO_CYC    = 2;
  localparam int unsigned PWR_DN_CYC = 4;
  localparam int unsigned IDLE_CYC   = 16;
  localparam int WState = 0;
  localparam int WGnt   = 1;
  localparam int WBusy  = 2;
  localparam int WPwr   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       op_req = 1'b0;
  logic       alu_busy = 1'b0;
  logic       auto_sleep_en = 1'b0;
  logic       force_sleep = 1'b0;
  logic       op_gnt, alu_start, alu_pwr_en, iso_en;
  logic [2:0] pwr_state;

  alu_pwr_ctrl #(
    .PWR_UP_CYC(PWR_UP_CYC),
    .ISO_CYC   (ISO_CYC),
    .PWR_DN_CYC(PWR_DN_CYC),
    .IDLE_CYC  (IDLE_CYC),
    .CNT_W     (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_req       (op_req),
    .op_gnt       (op_gnt),
    .alu_start    (alu_start),
    .alu_busy     (alu_busy),
    .auto_sleep_en(auto_sleep_en),
    .force_sleep  (force_sleep),
    .alu_pwr_en   (alu_pwr_en),
    .iso_en       (iso_en),
    .pwr_state    (pwr_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [6:0] exp_q[$];

  // Reference model: counts cycles spent in each state upward from entry.
  int   m_state = 0;
  int   m_t = 0;
  int   m_idle = 0;
  logic m_gnt = 1'b0;

  int   busy_left = 0;
  logic pend = 1'b0;
  logic prev_pwr = 1'b0;
  int   iso_run = 0;
  logic rst_at_edge;
  logic busy_at_edge;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int   nxt;
    logic g, idle_c;
    nxt = m_state;
    g   = 1'b0;
    if (!rst_n) begin
      nxt = 0;
    end else begin
      case (m_state)
        0: if (op_req && !force_sleep) nxt = 1;
        1: if (m_t + 1 == int'(PWR_UP_CYC)) nxt = 2;
        2: begin
          idle_c = !op_req && !alu_busy && !m_gnt;
          g      = op_req && !alu_busy && !force_sleep && !m_gnt;
          m_idle = idle_c ? m_idle + 1 : 0;
          if ((force_sleep && !alu_busy) || (auto_sleep_en && m_idle >= int'(IDLE_CYC))) nxt = 3;
        end
        3: if (m_t + 1 == int'(ISO_CYC)) nxt = 4;
        4: if (m_t + 1 == int'(PWR_DN_CYC)) nxt = 0;
        default: nxt = 0;
      endcase
    end
    m_t = (!rst_n || nxt != m_state) ? 0 : m_t + 1;
    if (nxt != 2) m_idle = 0;
    m_gnt   = g;
    m_state = nxt;
    exp_q.push_back({3'(nxt), (nxt >= 1 && nxt <= 3), (nxt != 2), g, g});
  endtask

  task automatic tick();
    logic [6:0] exp_v, obs_v;
    model_step();
    rst_at_edge  = rst_n;
    busy_at_edge = alu_busy;
    @(posedge clk);
    #1;
    obs_v = {pwr_state, alu_pwr_en, iso_en, op_gnt, alu_start};
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'(exp_q.size()), 1);
    end else begin
      exp_v = exp_q.pop_front();
      check("sb_state_pwr_iso_gnt_start", obs_v, exp_v);
    end
    check("iso_needs_pwr", iso_en | alu_pwr_en, 1);
    check("start_only_on", !alu_start || (pwr_state == 3'd2), 1);
    if (prev_pwr && !alu_pwr_en && rst_at_edge) check("iso_lead", iso_run >= ISO_CYC, 1);
    prev_pwr = alu_pwr_en;
    iso_run  = iso_en ? iso_run + 1 : 0;
    // ALU stand-in: samples start one edge later, then busy for 5 cycles.
    if (busy_left > 0) busy_left--;
    if (pend) begin
      busy_left = 5;
      pend = 1'b0;
    end
    if (alu_start) pend = 1'b1;
    alu_busy = busy_left > 0;
  endtask

  function automatic logic cond_met(input int sel, input logic [2:0] val);
    case (sel)
      WState:  return pwr_state == val;
      WGnt:    return op_gnt == val[0];
      WBusy:   return alu_busy == val[0];
      default: return alu_pwr_en == val[0];
    endcase
  endfunction

  task automatic wait_for(input string tag, input int sel, input logic [2:0] val, input int max,
                          output int n);
    logic hit;
    hit = 1'b0;
    n = 0;
    while (!hit && n < max) begin
      tick();
      n++;
      hit = cond_met(sel, val);
    end
    check(tag, hit, 1);
  endtask

  task automatic settle();
    int n;
    wait_for("busy_rise", WBusy, 3'd1, 10, n);
    wait_for("busy_fall", WBusy, 3'd0, 10, n);
  endtask

  task automatic reset_check(input string tag);
    rst_n = 1'b0;
    tick();
    check({tag, "_state"}, pwr_state, 0);
    check({tag, "_pwr"}, alu_pwr_en, 0);
    check({tag, "_iso"}, iso_en, 1);
    check({tag, "_gnt"}, {op_gnt, alu_start}, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   n, lat, grants, rises, g;
    logic prev_gnt, prev_busy;

    reset_check("rst_off");

    // Cold wake.
    op_req = 1'b1;
    lat = -1;
    for (int t = 0; t <= 20; t++) begin
      tick();
      if (t == 0) check("wake_pwr", alu_pwr_en, 1);
      if (t == 7) check("wake_iso_pu", iso_en, 1);
      if (t == 8) check("wake_iso_on", iso_en, 0);
      if (op_gnt) begin
        lat = t;
        break;
      end
    end
    check("wake_lat", lat, PWR_UP_CYC + 1);
    op_req = 1'b0;
    tick();
    check("gnt_pulse", {op_gnt, alu_start}, 0);
    settle();

    // Back-to-back requests against a 5-cycle busy ALU.
    op_req = 1'b1;
    grants = 0;
    rises = 0;
    prev_gnt = 1'b0;
    for (int t = 0; t < 45; t++) begin
      if (t == 35) op_req = 1'b0;
      prev_busy = alu_busy;
      tick();
      if (op_gnt) begin
        grants++;
        check("gnt_adjacent", prev_gnt, 0);
        check("gnt_while_busy", busy_at_edge, 0);
      end
      if (alu_busy && !prev_busy) rises++;
      prev_gnt = op_gnt;
    end
    check("b2b_grants", grants, 5);
    check("b2b_busy_periods", rises, 5);

    // Auto-sleep: a request at idle count 15 restarts the count.
    auto_sleep_en = 1'b1;
    op_req = 1'b1;
    tick();
    check("as_gnt", op_gnt, 1);
    op_req = 1'b0;
    settle();
    repeat (15) tick();
    check("as_idle15_on", pwr_state, 2);
    op_req = 1'b1;
    tick();
    check("as_idle15_gnt", op_gnt, 1);
    op_req = 1'b0;
    settle();
    wait_for("as_iso", WState, 3'd3, 40, n);
    check("as_idle_cnt", n, IDLE_CYC);
    wait_for("as_pwr_off", WPwr, 3'd0, 10, n);
    check("as_iso_cyc", n, ISO_CYC);
    wait_for("as_off", WState, 3'd0, 10, n);
    check("as_pdn_cyc", n, PWR_DN_CYC);
    auto_sleep_en = 1'b0;

    // force_sleep together with op_req while busy.
    op_req = 1'b1;
    wait_for("fs_wake_gnt", WGnt, 3'd1, 20, n);
    op_req = 1'b0;
    wait_for("fs_busy", WBusy, 3'd1, 5, n);
    force_sleep = 1'b1;
    op_req = 1'b1;
    g = 0;
    n = 0;
    while (alu_busy && n < 10) begin
      tick();
      n++;
      if (op_gnt) g++;
    end
    check("fs_hold_on", pwr_state, 2);
    tick();
    check("fs_iso", pwr_state, 3);
    for (int t = 0; t < 12; t++) begin
      tick();
      if (op_gnt) g++;
    end
    check("fs_no_grant", g, 0);
    check("fs_off_held", pwr_state, 0);

    // Request arriving during power-down gets a full re-power.
    force_sleep = 1'b0;
    wait_for("pd_wake_gnt", WGnt, 3'd1, 20, n);
    op_req = 1'b0;
    settle();
    force_sleep = 1'b1;
    wait_for("pd_iso", WState, 3'd3, 5, n);
    force_sleep = 1'b0;
    wait_for("pd_pdn", WState, 3'd4, 5, n);
    check("pd_iso_cyc", n, ISO_CYC);
    op_req = 1'b1;
    wait_for("pd_off", WState, 3'd0, 10, n);
    check("pd_pdn_cyc", n, PWR_DN_CYC);
    tick();
    check("pd_rewake", pwr_state, 1);
    wait_for("pd_gnt", WGnt, 3'd1, 20, n);
    check("pd_gnt_lat", n, PWR_UP_CYC + 1);
    op_req = 1'b0;
    settle();
    reset_check("rst_on");

    // Reset in ISO_ON and PWR_DN.
    op_req = 1'b1;
    wait_for("ri_gnt", WGnt, 3'd1, 20, n);
    op_req = 1'b0;
    settle();
    force_sleep = 1'b1;
    wait_for("ri_iso", WState, 3'd3, 5, n);
    reset_check("rst_iso");
    force_sleep = 1'b0;
    op_req = 1'b1;
    wait_for("rp_gnt", WGnt, 3'd1, 20, n);
    op_req = 1'b0;
    settle();
    force_sleep = 1'b1;
    wait_for("rp_pdn", WState, 3'd4, 8, n);
    force_sleep = 1'b0;
    reset_check("rst_pdn");

    // Reset in the third PWR_UP cycle.
    op_req = 1'b1;
    repeat (3) tick();
    check("mw_pwr_up", pwr_state, 1);
    reset_check("rst_pwrup");
    op_req = 1'b0;
    repeat (3) tick();
    check("mw_stay_off", pwr_state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
